// File: rtl/ntt_masked_bfu_addsub_align_pkg.sv
// Shared types, constants and mod-q helpers for the masked butterfly add/sub alignment stage.
package ntt_masked_bfu_addsub_align_pkg;

  localparam int unsigned MLDSA_Q = 8380417;
  localparam int QW = 23;
  localparam logic [QW-1:0] Q_VAL = QW'(MLDSA_Q);
  localparam int MASKED_WIDTH = 46;
  localparam int MASKED_ADDSUB_LAT = 211;

  typedef logic [1:0][MASKED_WIDTH-1:0] masked_share_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } addsub_state_e;

  // Operands must already be in [0, q); one conditional correction is then sufficient.
  function automatic logic [QW-1:0] mod_add(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, Q_VAL}) ? QW'(s - {1'b0, Q_VAL}) : s[QW-1:0];
  endfunction

  function automatic logic [QW-1:0] mod_sub(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[QW] ? (d[QW-1:0] + Q_VAL) : d[QW-1:0];
  endfunction

endpackage

// File: rtl/ntt_masked_bfu_addsub_align_modq.sv
// Single-share modular add and subtract (combinational, zero latency, no flow control).
module ntt_masked_share_addsub_modq
  import ntt_masked_bfu_addsub_align_pkg::*;
(
  input  logic [QW-1:0] a,
  input  logic [QW-1:0] b,
  output logic [QW-1:0] sum,
  output logic [QW-1:0] diff
);

  assign sum  = mod_add(a, b);
  assign diff = mod_sub(a, b);

endmodule

// File: rtl/ntt_masked_bfu_addsub_align.sv
// Delays masked u shares by MULT_LAT, pairs them with the product and registers share-wise u+m / u-m mod q
// (latency MULT_LAT+1, no backpressure). Optional share refresh with rnd: NTT_MASKED_ADDSUB_REFRESH_EN.
module ntt_masked_bfu_addsub_align
  import ntt_masked_bfu_addsub_align_pkg::*;
#(
  parameter int WIDTH    = 46,
  parameter int MULT_LAT = 210,
  parameter int PTR_W    = $clog2(MULT_LAT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  in_valid,
  input  logic [1:0][WIDTH-1:0] u_in,
  input  logic [WIDTH-1:0][1:0] mul_res,
  input  logic [WIDTH-1:0]      rnd,
  output logic [1:0][WIDTH-1:0] add_res,
  output logic [1:0][WIDTH-1:0] sub_res,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic                  clr;
  logic [QW-1:0]         buf_u0 [MULT_LAT];
  logic [QW-1:0]         buf_u1 [MULT_LAT];
  logic [MULT_LAT-1:0]   buf_vld;
  logic [PTR_W-1:0]      ptr;
  logic [CNT_W-1:0]      inflight;
  addsub_state_e         state, state_nxt;
  logic                  pop_vld;
  logic [1:0][QW-1:0]    pop_u, mul_m;
  logic [1:0][WIDTH-1:0] mul_full;
  logic [1:0][QW-1:0]    add_c, sub_c, add_f, sub_f;
  logic [1:0][QW-1:0]    add_q, sub_q;
  logic                  hi_bits_unused;
  logic                  rnd_unused;

  assign clr = reset | zeroize;

  // Read-before-write on the same slot gives exactly MULT_LAT cycles of delay.
  assign pop_vld  = buf_vld[ptr];
  assign pop_u[0] = buf_u0[ptr];
  assign pop_u[1] = buf_u1[ptr];

  always_ff @(posedge clk) begin
    buf_u0[ptr] <= u_in[0][QW-1:0];
    buf_u1[ptr] <= u_in[1][QW-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      buf_vld <= '0;
      ptr     <= '0;
    end else begin
      buf_vld[ptr] <= in_valid;
      ptr          <= (ptr == PTR_W'(MULT_LAT - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    mul_full = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        mul_full[s][i] = mul_res[i][s];
      end
    end
  end

  assign mul_m[0] = mul_full[0][QW-1:0];
  assign mul_m[1] = mul_full[1][QW-1:0];
  assign hi_bits_unused = ^{u_in[0][WIDTH-1:QW], u_in[1][WIDTH-1:QW],
                            mul_full[0][WIDTH-1:QW], mul_full[1][WIDTH-1:QW]};

  for (genvar s = 0; s < 2; s++) begin : g_share
    ntt_masked_share_addsub_modq u_modq (
      .a    (pop_u[s]),
      .b    (mul_m[s]),
      .sum  (add_c[s]),
      .diff (sub_c[s])
    );
  end

`ifdef NTT_MASKED_ADDSUB_REFRESH_EN
  logic [QW-1:0] r_raw, r_red;
  assign r_raw      = rnd[QW-1:0];
  assign r_red      = (r_raw >= Q_VAL) ? (r_raw - Q_VAL) : r_raw;
  // +r on share 0 and -r on share 1 keeps the share sum unchanged mod q.
  assign add_f[0]   = mod_add(add_c[0], r_red);
  assign add_f[1]   = mod_sub(add_c[1], r_red);
  assign sub_f[0]   = mod_add(sub_c[0], r_red);
  assign sub_f[1]   = mod_sub(sub_c[1], r_red);
  assign rnd_unused = ^rnd[WIDTH-1:QW];
`else
  assign add_f      = add_c;
  assign sub_f      = sub_c;
  assign rnd_unused = ^rnd;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      add_q     <= '0;
      sub_q     <= '0;
    end else begin
      out_valid <= pop_vld;
      if (pop_vld) begin
        add_q <= add_f;
        sub_q <= sub_f;
      end
    end
  end

  always_comb begin
    add_res = '0;
    sub_res = '0;
    for (int s = 0; s < 2; s++) begin
      add_res[s][QW-1:0] = add_q[s];
      sub_res[s][QW-1:0] = sub_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inflight <= '0;
    end else if (in_valid && !pop_vld) begin
      inflight <= inflight + 1'b1;
    end else if (!in_valid && pop_vld) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (!in_valid) state_nxt = (inflight != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (in_valid)              state_nxt = RUN;
        else if (inflight == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_ntt_masked_bfu_addsub_align.sv
// Scoreboard bench for ntt_masked_bfu_addsub_align: random and directed ops against a mod-q reference model.
module tb_ntt_masked_bfu_addsub_align;

  localparam int     W   = 46;
  localparam int     LAT = 210;
  localparam longint Q   = 8380417;

  typedef struct {
    int     due;
    longint a0, a1, s0, s1;
  } exp_t;

  typedef struct {
    longint m0, m1;
  } mul_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                zeroize = 1'b0;
  logic                in_valid = 1'b0;
  logic [1:0][W-1:0]   u_in = '0;
  logic [W-1:0][1:0]   mul_res = '0;
  logic [W-1:0]        rnd = '0;
  logic [1:0][W-1:0]   add_res, sub_res;
  logic                out_valid, busy;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     n_pops = 0;
  exp_t   exp_q[$];
  mul_t   mul_at[int];
  longint rnd_hist[int];

  ntt_masked_bfu_addsub_align dut (
    .clk       (clk),
    .reset     (reset),
    .zeroize   (zeroize),
    .in_valid  (in_valid),
    .u_in      (u_in),
    .mul_res   (mul_res),
    .rnd       (rnd),
    .add_res   (add_res),
    .sub_res   (sub_res),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Multiplier stand-in: scheduled products appear exactly LAT cycles after launch, garbage otherwise.
  initial begin
    mul_t m;
    forever begin
      @(posedge clk);
      #1;
      if (mul_at.exists(cyc)) begin
        m = mul_at[cyc];
        mul_at.delete(cyc);
      end else begin
        m.m0 = longint'({$urandom, $urandom});
        m.m1 = longint'({$urandom, $urandom});
      end
      for (int i = 0; i < W; i++) begin
        mul_res[i][0] = m.m0[i];
        mul_res[i][1] = m.m1[i];
      end
      rnd = W'({$urandom, $urandom});
      rnd_hist[cyc] = longint'(rnd);
    end
  end

  // Monitor: every out_valid pops one expected result.
  initial begin
    exp_t   e;
    longint r;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
`ifdef NTT_MASKED_ADDSUB_REFRESH_EN
          r = rnd_hist.exists(cyc - 1) ? (rnd_hist[cyc - 1] & 64'h7FFFFF) : 0;
          if (r >= Q) r = r - Q;
          e.a0 = (e.a0 + r) % Q;
          e.a1 = (e.a1 + Q - r) % Q;
          e.s0 = (e.s0 + r) % Q;
          e.s1 = (e.s1 + Q - r) % Q;
`else
          r = 0;
`endif
          check("out_cycle", 64'(cyc), 64'(e.due));
          check("add0", 64'(add_res[0]), e.a0 + r - r);
          check("add1", 64'(add_res[1]), e.a1);
          check("sub0", 64'(sub_res[0]), e.s0);
          check("sub1", 64'(sub_res[1]), e.s1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (in_valid === 1'b1)
      assert (u_in[0] < W'(Q) && u_in[1] < W'(Q)) else $error("input share out of range");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input longint u0, input longint u1, input longint m0, input longint m1,
                       input longint a0, input longint a1, input longint s0, input longint s1);
    exp_t e;
    mul_t m;
    in_valid = 1'b1;
    u_in[0]  = W'(u0);
    u_in[1]  = W'(u1);
    m.m0 = m0;
    m.m1 = m1;
    mul_at[cyc + LAT] = m;
    e.due = cyc + LAT + 1;
    e.a0 = a0; e.a1 = a1; e.s0 = s0; e.s1 = s1;
    exp_q.push_back(e);
  endtask

  task automatic issue_m(input longint u0, input longint u1, input longint m0, input longint m1);
    issue(u0, u1, m0, m1, (u0 + m0) % Q, (u1 + m1) % Q, (u0 - m0 + Q) % Q, (u1 - m1 + Q) % Q);
  endtask

  function automatic longint rand_share();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return 0;
    if (sel == 1) return Q - 1;
    return longint'($urandom_range(0, int'(Q - 1)));
  endfunction

  task automatic pulse_clear(input bit use_zeroize, input int n);
    tick();
    if (use_zeroize) zeroize = 1'b1;
    else             reset   = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    mul_at.delete();
    repeat (n - 1) @(posedge clk);
    #1;
    reset   = 1'b0;
    zeroize = 1'b0;
    @(negedge clk);
    check(use_zeroize ? "zeroize_out_valid" : "reset_out_valid", 64'(out_valid), 64'd0);
    check(use_zeroize ? "zeroize_add_res" : "reset_add_res", 64'(add_res[0] | add_res[1]), 64'd0);
    check(use_zeroize ? "zeroize_sub_res" : "reset_sub_res", 64'(sub_res[0] | sub_res[1]), 64'd0);
    check(use_zeroize ? "zeroize_busy" : "reset_busy", 64'(busy), 64'd0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t;
    int last;
    int p0;
    int z0;

    repeat (2) @(posedge clk);
    pulse_clear(1'b0, 3);

    // Reset mid-run: in-flight ops must never surface.
    for (int k = 0; k < 20; k++) begin
      tick();
      issue_m(rand_share(), rand_share(), rand_share(), rand_share());
    end
    repeat (50) tick();
    pulse_clear(1'b0, 3);
    repeat (LAT + 20) tick();
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);

    // Single op with hand-computed results and busy window.
    tick();
    t = cyc;
    issue(5, 10, 100, 200, 105, 210, 8380322, 8380227);
    @(negedge clk);
    check("busy_t0", 64'(busy), 64'd0);
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("busy_t+%0d", k), 64'(busy), 64'(k <= LAT + 1));
    end

    // Modular boundaries.
    tick();
    issue(8380416, 0, 1, 0, 0, 0, 8380415, 0);
    tick();
    issue(0, 3, 8380416, 5, 8380416, 8, 1, 8380415);
    drain(LAT + 20);

    // 300 back-to-back ops wrap the buffer.
    p0 = n_pops;
    for (int k = 0; k < 300; k++) begin
      tick();
      issue_m(longint'(k), longint'(2 * k), longint'(k + 1), 0);
    end
    last = cyc;
    while (cyc < last + LAT + 1) tick();
    @(negedge clk);
    check("stream_busy_last", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("stream_busy_idle", 64'(busy), 64'd0);
    check("stream_pulses", 64'(n_pops - p0), 64'd300);

    // Random ops with random gaps.
    for (int k = 0; k < 60; k++) begin
      tick();
      if ($urandom_range(0, 2) != 0)
        issue_m(rand_share(), rand_share(), rand_share(), rand_share());
    end
    drain(LAT + 20);

    // Zeroize mid-stream, then a fresh op.
    tick();
    z0 = cyc;
    issue_m(rand_share(), rand_share(), rand_share(), rand_share());
    for (int k = 1; k < 50; k++) begin
      tick();
      issue_m(rand_share(), rand_share(), rand_share(), rand_share());
    end
    while (cyc < z0 + 99) tick();
    pulse_clear(1'b1, 1);
    repeat (LAT + 40) tick();
    @(negedge clk);
    check("post_zeroize_busy", 64'(busy), 64'd0);
    tick();
    issue_m(12345, 8380000, 777, 8380416);
    drain(LAT + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/ntt_masked_bfu_addsub_align.md
Name: ntt_masked_bfu_addsub_align

Overview:
- Downstream stage of the masked butterfly multiplier (two-share mult → A2B → reduction → B2A, 210 clk total).
- Delays the butterfly "u" operand shares by exactly the multiplier latency. Pairs them with the multiplier's two-share product.
- Produces share-wise masked u+m and u−m mod MLDSA_Q.
- Tracks in-flight operations with a run/drain FSM so the NTT controller knows when the pipe is empty.

Parameters:
- WIDTH, 46: share container width; matches multiplier WIDTH.
- MULT_LAT, 210: multiplier latency in clks; equals delay-buffer depth.
- PTR_W, $clog2(MULT_LAT): buffer pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- zeroize  in  1  synchronous clear, same effect as reset.
- in_valid  in  1  u_in valid; asserted in the same cycle the multiplier operands are launched.
- u_in  in  [1:0][WIDTH-1:0]  arithmetic shares of u; each share in [0, MLDSA_Q).
- mul_res  in  [1:0] x [WIDTH-1:0] (bit-sliced)  multiplier output; bit i of share s is at [i][s]; each share in [0, MLDSA_Q).
- rnd  in  WIDTH  refresh randomness; used only with the optional feature.
- add_res  out  [1:0][WIDTH-1:0]  shares of u+m mod q.
- sub_res  out  [1:0][WIDTH-1:0]  shares of u−m mod q.
- out_valid  out  1  results valid, one-cycle pulse per op.
- busy  out  1  high while any op is in flight.

Behaviour:
- Reset or zeroize, synchronous, highest priority:
  - All outputs are 0.
  - Buffer valid bits, pointer, in-flight counter and FSM are cleared; FSM goes to IDLE.
  - The buffer data RAM need not be cleared, because entries with valid=0 are never consumed.
- Delay buffer:
  - Circular buffer with MULT_LAT entries of {valid, u share0, u share1} and a single pointer ptr.
  - Each cycle the buffer reads entry[ptr], then writes {in_valid, u_in} to entry[ptr].
  - ptr increments and wraps from MULT_LAT−1 to 0.
  - Net delay is exactly MULT_LAT cycles. Every cycle writes, including in_valid=0 cycles (valid=0).
- Alignment:
  - The entry read in cycle t+MULT_LAT is paired with mul_res sampled in that same cycle.
  - mul_res is unpacked to packed shares m0, m1.
- Arithmetic, per share s (share-wise, no share combination):
  - add_s = u_s + m_s; subtract q if the result is ≥ q. Computed in 24 bits, zero-extended to WIDTH.
  - sub_s = u_s − m_s; add q if the result is negative.
  - Share sums then satisfy add0+add1 ≡ u+m and sub0+sub1 ≡ u−m (mod q).
- Output register:
  - add_res, sub_res and out_valid are registered.
  - Total latency from in_valid to out_valid is MULT_LAT+1.
  - When the popped valid bit is 0, result registers hold their previous value and out_valid=0.
- Counter:
  - inflight increments on in_valid and decrements on a popped valid; both in the same cycle means no change.
  - Range 0..MULT_LAT. It cannot overflow because there is at most one push per cycle.
- FSM:
  - IDLE → RUN on in_valid.
  - RUN → DRAIN when in_valid=0 and inflight>0.
  - DRAIN → RUN on in_valid.
  - DRAIN → IDLE when inflight reaches 0 with no push.
  - busy = (state != IDLE).
- Back-to-back ops are unlimited with one result per cycle, in order. There is no backpressure: the consumer must accept every out_valid.
- Inputs with share values ≥ q produce undefined results; this is an assertion in the bench.

Optional Feature:
- Macro NTT_MASKED_ADDSUB_REFRESH_EN.
- Defined: after reduction, add_res = ((add0+r) mod q, (add1−r) mod q), with the same refresh applied to sub_res, where r = rnd[22:0] mod q (one conditional subtract). Latency is unchanged.
- Undefined: no refresh; rnd is unused.

Decomposition:
- Add to ntt_defines_pkg:
  - typedef masked_share_t [1:0][WIDTH-1:0];
  - enum addsub_state_e {IDLE, RUN, DRAIN};
  - localparam MASKED_ADDSUB_LAT = 211.
- MLDSA_Q comes from abr_params_pkg.
- One combinational sub-module, ntt_masked_share_addsub_modq: single-share modular add and sub, instantiated twice (once per share).

Test Plan:
- Reset/idle: assert reset for 3 clks mid-run → add_res=sub_res=0, out_valid=0, busy=0 next cycle, no stale outputs afterwards.
- Single op:
  - Stimulus: u=(5,10) at cycle t; mul_res=(100,200) at t+210.
  - Response at t+211: add=(105,210), sub=(8380322,8380227), out_valid for one cycle only.
  - busy high from t+1 to t+211.
- Modular boundaries: u0=8380416 with m0=1 → add0=0; u1=0 with m1=0 → sub1=0; u0=0 with m0=8380416 → sub0=1.
- Streaming and wrap: 300 consecutive ops with u=(k,2k) and mul_res=(k+1,0) → 300 consecutive out_valid pulses, add0=2k+1 in order; FSM goes RUN → DRAIN → IDLE 211 clks after the last op.
- Zeroize mid-stream: 50 ops, zeroize at the 100th cycle → no out_valid for those ops, busy=0, state IDLE; a fresh op afterwards returns correctly.
- Refresh (macro defined): the single-op case with rnd=7 → add=(112,203), sub=(8380329,8380220); share sums are unchanged mod q.
